// File: rtl/apb_completer_mem_pkg.sv
// Shared types and address-to-protection mapping for the APB completer memory
// and the bridge that drives it.
package apb_completer_mem_pkg;

  typedef logic [2:0] pprot_t;

  localparam int PROT_PRIV_BIT  = 4;
  localparam int PROT_NS_BIT    = 5;
  localparam int PROT_INSTR_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_VIOL   = 2'd2
  } completer_state_e;

  // Address bits 6:4 name the pprot attributes a region demands.
  function automatic pprot_t required_pprot(input logic [6:0] addr_lo);
    pprot_t req;
    req[0] = addr_lo[PROT_PRIV_BIT];
    req[1] = addr_lo[PROT_NS_BIT];
    req[2] = addr_lo[PROT_INSTR_BIT];
    return req;
  endfunction

  // Bridge side: the minimal pprot that satisfies the target region.
  function automatic pprot_t get_pprot(input logic [6:0] addr_lo);
    return required_pprot(addr_lo);
  endfunction

  // Bridge side: place an address in the region whose requirement is prot.
  function automatic logic [31:0] get_addr_for_pprot(input logic [31:0] base,
                                                     input pprot_t prot);
    logic [31:0] a;
    a = base;
    a[PROT_PRIV_BIT]  = prot[0];
    a[PROT_NS_BIT]    = prot[1];
    a[PROT_INSTR_BIT] = prot[2];
    return a;
  endfunction

endpackage

// File: rtl/apb_completer_mem_if.sv
// APB4 bus bundle between a requester (master) and a completer (slave).
// Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access
// cycles (psel=1, penable=1) with stable requester signals; it completes on the
// first access cycle where pready=1, and pslverr/prdata are valid only then.
interface apb_completer_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_completer_mem_reg_mem.sv
// Byte-strobed register array: async clear, one write port, combinational read.
module apb_completer_mem_reg_mem #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a word-addressed register memory, with alignment,
// range, region-protection and handshake checking and programmable wait states.
module apb_completer_mem
  import apb_completer_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                       pclk,
  input  logic                       presetn,
  apb_completer_mem_if.slave         bus,
  output completer_state_e           dbg_state
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  completer_state_e      state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic                  cap_write;
  logic                  cap_err;
  logic [IDX_W-1:0]      cap_idx;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_WIDTH-1:0] cap_strb;
  logic                  setup_err;
  logic                  setup_seen;
  logic                  done;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign setup_seen = (state == ST_IDLE) && bus.psel && !bus.penable;
  assign done       = (state == ST_ACCESS) && (cnt == '0);
  assign dbg_state  = state;

  assign setup_err = (bus.paddr[1:0] != 2'b00)
                   || (bus.paddr >= ADDR_WIDTH'(4 * DEPTH))
                   || ((required_pprot(bus.paddr[6:0]) & ~bus.pprot) != '0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Completion wins over a late psel drop: the result is already on the bus.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (bus.penable)  state_n = ST_VIOL;
        else if (bus.psel) state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt == '0)     state_n = ST_IDLE;
        else if (!bus.psel) state_n = ST_VIOL;
      end
      ST_VIOL: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    if (done) begin
      bus.pready  = 1'b1;
      bus.pslverr = cap_err;
      if (!cap_err && !cap_write) bus.prdata = mem_rdata;
    end else if (state == ST_VIOL) begin
      bus.pready  = 1'b1;
      bus.pslverr = 1'b1;
    end
  end

  // Request fields are frozen at setup; access-phase changes are ignored.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else if (setup_seen) begin
      cnt       <= CNT_W'(WAIT_STATES);
      cap_write <= bus.pwrite;
      cap_err   <= setup_err;
      cap_idx   <= bus.paddr[IDX_W+1:2];
      cap_wdata <= bus.pwdata;
      cap_strb  <= bus.pstrb;
    end else if ((state == ST_ACCESS) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign mem_we = done && cap_write && !cap_err;

  apb_completer_mem_reg_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (mem_we),
    .idx   (cap_idx),
    .wdata (cap_wdata),
    .strb  (cap_strb),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed and lightly randomised bench for apb_completer_mem with a
// scoreboard queue of expected {pslverr, prdata} completions.
module tb_apb_completer_mem;
  import apb_completer_mem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 64;
  localparam int WS    = 1;
  localparam int EW    = DW + 1;

  // clock / reset
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb_completer_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  completer_state_e dbg_state;

  apb_completer_mem #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STRB_WIDTH  (SW),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model [DEPTH];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [AW-1:0] a, input logic [2:0] p);
    logic [2:0] req;
    req = {a[6], a[5], a[4]};
    return (a[1:0] != 2'b00) || (a >= AW'(4 * DEPTH)) || ((req & ~p) != 3'b000);
  endfunction

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    bus.pprot   = '0;
  endtask

  // driver: full APB transfer; access-phase address/data are scrambled on purpose
  task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
    logic          e;
    logic [DW-1:0] ed;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    int            waits;
    e  = exp_err(a, p);
    ed = (!e && !wr) ? model[a[7:2]] : '0;
    exp_q.push_back({e, ed});
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = d; bus.pstrb = s; bus.pprot = p;
    @(negedge pclk);
    bus.penable = 1'b1;
    bus.paddr   = a ^ 32'h0000_0008;
    bus.pwdata  = ~d;
    waits = 0;
    while (bus.pready !== 1'b1 && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    chk({tag, "_waits"}, 64'(waits), 64'(WS));
    got = {bus.pslverr, bus.prdata};
    exp = exp_q.pop_front();
    chk(tag, 64'(got), 64'(exp));
    if (wr && !e) begin
      for (int b = 0; b < SW; b++) if (s[b]) model[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
    end
    @(posedge pclk);
    #1 bus.psel = 1'b0;
    bus.penable = 1'b0;
  endtask

  initial begin
    bus_idle();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_pready", 64'(bus.pready), 64'(0));
    chk("rst_pslverr", 64'(bus.pslverr), 64'(0));
    chk("rst_prdata", 64'(bus.prdata), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    presetn = 1'b1;

    xfer("rd04_init", 1'b0, 32'h04, '0, '0, 3'b000);
    xfer("wr04", 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 3'b000);
    xfer("rd04", 1'b0, 32'h04, '0, '0, 3'b000);
    chk("model04", 64'(model[1]), 64'h0000_0000_FFFF_FFFF);

    xfer("wr84_lane0", 1'b1, 32'h84, 32'hFFFF_FFFF, 4'h1, 3'b000);
    xfer("rd84", 1'b0, 32'h84, '0, '0, 3'b000);
    chk("model84", 64'(model[33]), 64'h0000_0000_0000_00FF);
    xfer("wr84_nostrb", 1'b1, 32'h84, 32'h1234_5678, 4'h0, 3'b000);
    xfer("rd84_nostrb", 1'b0, 32'h84, '0, '0, 3'b000);

    xfer("wr74_ok", 1'b1, 32'h74, 32'hA5A5_A5A5, 4'hF, 3'b111);
    xfer("wr74_p110", 1'b1, 32'h74, 32'h0000_0000, 4'hF, 3'b110);
    xfer("wr74_p101", 1'b1, 32'h74, 32'h1111_1111, 4'hF, 3'b101);
    xfer("rd74_p011", 1'b0, 32'h74, '0, '0, 3'b011);
    xfer("rd74_ok", 1'b0, 32'h74, '0, '0, 3'b111);
    chk("model74", 64'(model[29]), 64'h0000_0000_A5A5_A5A5);

    xfer("rd03_unaligned", 1'b0, 32'h03, '0, '0, 3'b111);
    xfer("wr06_unaligned", 1'b1, 32'h06, 32'hDEAD_BEEF, 4'hF, 3'b111);
    xfer("rd100_range", 1'b0, 32'h100, '0, '0, 3'b111);
    xfer("rd00_after_err", 1'b0, 32'h00, '0, '0, 3'b000);

    // access phase with psel dropped
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h0C; bus.pwdata = 32'hCAFE_F00D; bus.pstrb = 4'hF; bus.pprot = 3'b000;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b1;
    @(negedge pclk);
    chk("viol_pready", 64'(bus.pready), 64'(1));
    chk("viol_pslverr", 64'(bus.pslverr), 64'(1));
    chk("viol_prdata", 64'(bus.prdata), 64'(0));
    chk("viol_state", 64'(dbg_state), 64'(ST_VIOL));
    bus.penable = 1'b0;
    @(negedge pclk);
    chk("viol_one_cycle", 64'(bus.pready), 64'(0));
    xfer("rd0c_after_viol", 1'b0, 32'h0C, '0, '0, 3'b000);

    // penable without a setup
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b1;
    @(negedge pclk);
    chk("noset_pready", 64'(bus.pready), 64'(1));
    chk("noset_pslverr", 64'(bus.pslverr), 64'(1));
    bus.penable = 1'b0;
    @(negedge pclk);
    chk("noset_release", 64'(bus.pready), 64'(0));

    // randomised aligned traffic with back-to-back transfers
    for (int n = 0; n < 8; n++) begin
      int unsigned idx;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      idx = $urandom_range(0, DEPTH - 1);
      d   = DW'($urandom);
      s   = SW'($urandom_range(0, 15));
      xfer("rnd_wr", 1'b1, AW'(idx) << 2, d, s, 3'b111);
      xfer("rnd_rd", 1'b0, AW'(idx) << 2, '0, '0, 3'b111);
    end

    // reset in the middle of a write
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h08; bus.pwdata = 32'h5555_AAAA; bus.pstrb = 4'hF; bus.pprot = 3'b000;
    @(negedge pclk);
    bus.penable = 1'b1;
    presetn = 1'b0;
    #1;
    chk("midrst_pready", 64'(bus.pready), 64'(0));
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge pclk);
    bus_idle();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    presetn = 1'b1;
    xfer("rd08_after_rst", 1'b0, 32'h08, '0, '0, 3'b000);
    xfer("rd04_after_rst", 1'b0, 32'h04, '0, '0, 3'b000);

    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
